// File: rtl/bcd_digit_pkg.sv
// Shared widths, direction codes and the load clamp helper for the BCD
// digit counter.
package bcd_digit_pkg;
   localparam int DIGIT_W = 4;
   localparam int PC_W    = 16;
   localparam int DC_W    = 8;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // A loaded value above the top digit saturates to the top digit, so the
   // digit output can never leave the 0..MAX range.
   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v,
                                                      input logic [DIGIT_W-1:0] max_v);
      return (v > max_v) ? max_v : v;
   endfunction
endpackage

// File: rtl/bcd_digit_counter_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a debounce
// counter. Produces the accepted button level and a single-cycle pulse on
// every accepted rising transition.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   btn_raw    : raw asynchronous button input
//   level      : debounced button level (registered)
//   rise_pulse : high in the cycle a 0->1 change is accepted (combinational)
module btn_debounce
   import bcd_digit_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic rise_pulse
);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE - 1);

   logic            s1, s2;
   logic [DC_W-1:0] dc;
   logic            accept;

   // The counter only runs while the synchronised input disagrees with the
   // accepted level; any agreement restarts the count.
   assign accept     = (s2 != level) && (dc == DC_LAST);
   assign rise_pulse = accept && s2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         dc    <= '0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         if (s2 == level) begin
            dc <= '0;
         end else if (accept) begin
            level <= s2;
            dc    <= '0;
         end else begin
            dc <= dc + 1'b1;
         end
      end
   end
endmodule

// File: rtl/bcd_digit_counter.sv
// Single BCD digit sequencer feeding a 7-segment decoder. Advances on a
// prescaler tick or a debounced button step, counts up or down, supports a
// clamped synchronous load, flags wraps for cascading and blinks the decimal
// point on every tick.
//   clk, rst_n : clock, synchronous active-low reset
//   run        : prescaler enable
//   dir        : 1 = up, 0 = down
//   step_btn   : raw manual step button
//   load       : load strobe, load_val the value to load
//   digit      : current digit (registered)
//   wrap       : one-cycle pulse after a wrapping advance
//   dp         : decimal point, toggles per tick
module bcd_digit_counter
   import bcd_digit_pkg::*;
#(
   parameter int DIV       = 1000,
   parameter int DEBOUNCE  = 4,
   parameter int MAX_DIGIT = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               dir,
   input  logic               step_btn,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   output logic [DIGIT_W-1:0] digit,
   output logic               wrap,
   output logic               dp
);
   localparam logic [PC_W-1:0]    PC_LAST = PC_W'(DIV - 1);
   localparam logic [DIGIT_W-1:0] MAX_D   = DIGIT_W'(MAX_DIGIT);

   logic [PC_W-1:0] pc;
   logic            tick, step, adv;
   logic            unused_btn_level;

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (step_btn),
      .level      (unused_btn_level),
      .rise_pulse (step)
   );

   assign tick = run && (pc == PC_LAST);
   // A tick and a step landing together still count as a single advance.
   assign adv  = tick || step;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc    <= '0;
         digit <= '0;
         wrap  <= 1'b0;
         dp    <= 1'b0;
      end else begin
         // dp follows the tick even when a load swallows the advance.
         if (tick)
            dp <= ~dp;

         if (load)
            pc <= '0;
         else if (run)
            pc <= tick ? '0 : pc + 1'b1;

         if (load) begin
            digit <= clamp_digit(load_val, MAX_D);
            wrap  <= 1'b0;
         end else if (adv && (dir == DIR_UP)) begin
            digit <= (digit == MAX_D) ? '0 : digit + 1'b1;
            wrap  <= (digit == MAX_D);
         end else if (adv) begin
            digit <= (digit == '0) ? MAX_D : digit - 1'b1;
            wrap  <= (digit == '0);
         end else begin
            wrap <= 1'b0;
         end
      end
   end
endmodule

// File: doc/bcd_digit_counter.md
Name: bcd_digit_counter

Overview:
Single-digit BCD sequencer that produces the 4-bit digit code consumed by the downstream 7-segment decoder stage (digit[3:0] drives decoder inputs bit0..bit3).
- Counts 0..MAX_DIGIT up or down, advanced by a free-running prescaler tick and/or a debounced manual step button.
- Provides synchronous load, a one-cycle wrap pulse for cascading, and a decimal-point blink derived from the tick.

Parameters:
DIV, 1000, prescaler period in clk cycles; one tick every DIV cycles; legal range 2..65535
DEBOUNCE, 4, consecutive stable synchronised samples required before a step_btn level change is accepted; legal range 2..255
MAX_DIGIT, 9, highest digit value; legal range 1..15

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
run  input  1  1 = prescaler advances; 0 = prescaler holds its value
dir  input  1  1 = count up, 0 = count down
step_btn  input  1  raw, asynchronous, bouncy push button, active-high
load  input  1  synchronous load strobe
load_val  input  4  value loaded when load=1
digit  output  4  current digit, registered, to the 7-segment decoder
wrap  output  1  one-cycle pulse when the digit wraps (MAX_DIGIT->0 up, 0->MAX_DIGIT down)
dp  output  1  decimal point; toggles on every prescaler tick

Behaviour:
- Reset (rst_n=0 at an edge): digit=0, wrap=0, dp=0, prescaler=0, sync flops=0, debounced level=0, debounce counter=0. Reset overrides every input, including mid-count and mid-debounce.
- Prescaler: 16-bit counter pc. When run=1: if pc==DIV-1 then pc<=0 and tick=1 (combinational, same cycle); else pc<=pc+1. When run=0: pc holds and tick=0.
- Step path: two-flop synchroniser s1->s2. Debounce counter dc:
  - When s2 == debounced level, dc<=0.
  - Else, if dc==DEBOUNCE-1, the debounced level <= s2 and dc<=0 (accept); otherwise dc<=dc+1.
  - step=1 in the accept cycle only when s2=1 (rising accept). Falling accepts produce no event.
  - Latency: with step_btn held high, the digit changes on the (DEBOUNCE+2)-th rising edge after step_btn rises. Pulses shorter than DEBOUNCE stable s2 cycles are ignored.
- Advance event adv = tick OR step. Coincident tick and step produce exactly one advance.
- Digit update priority, evaluated each edge:
  1. load=1: digit<=min(load_val, MAX_DIGIT); pc<=0; wrap<=0. A tick or step in the same cycle is discarded; dp still toggles if tick=1.
  2. adv=1, dir=1: digit<=(digit==MAX_DIGIT)?0:digit+1; wrap<=(digit==MAX_DIGIT).
  3. adv=1, dir=0: digit<=(digit==0)?MAX_DIGIT:digit-1; wrap<=(digit==0).
  4. Otherwise: digit holds; wrap<=0.
- wrap is registered: high for exactly the one cycle following the wrapping edge. It is never high for two consecutive cycles unless two consecutive wrapping advances occur.
- dp<=~dp on every tick, independent of load and dir.
- digit is always within 0..MAX_DIGIT. A dir change takes effect on the next advance only.

Decomposition:
- Package bcd_digit_pkg: DIGIT_W=4, PC_W=16, DC_W=8; localparams DIR_UP=1'b1, DIR_DOWN=1'b0.
- One sub-module, btn_debounce (synchroniser + debounce counter + rising-accept pulse; parameter DEBOUNCE; ports clk, rst_n, btn_raw, level, rise_pulse). Prescaler and digit logic stay in the top.

Test Plan:
- Reset then count: DIV=4, run=1, dir=1 -> digit 0,1,2 on every 4th edge; dp toggles each tick; wrap=0.
- Up wrap: digit=9, tick -> digit=0, wrap=1 for exactly one cycle. Down wrap: dir=0, digit=0, tick -> digit=9, wrap=1 for one cycle.
- Load clamp and priority: load=1, load_val=4'hC coinciding with a tick -> digit=9, pc=0, wrap=0, dp toggled. Load load_val=3 -> digit=3.
- Debounce: DEBOUNCE=4, run=0, step_btn high for 3 cycles then low -> digit unchanged. Held high for 10 cycles -> digit+1 exactly once, on the 6th edge; release -> no further change.
- Coincident events: step accept on the same edge as a tick, dir=1, digit=5 -> digit=6 (not 7).
- Mid-operation reset: rst_n=0 for one edge with digit=7, pc=2, dc=2 -> all outputs 0 next cycle. Counting resumes from pc=0 and needs DIV cycles to the first tick.
